button_mbt_ctrl: RTL and testbench
==================================

// Module: button_mbt_ctrl
// PURPOSE
//  Pushbutton front end that drives the multi-boot trigger and LED level logic.
//  Synchronizes and debounces one raw button, then classifies each press as short or long.
//  Short presses step a 0..6 level for the LED bar; a long press arms multi-boot.
//  A short press within the arm window then emits the active-high mbt pulse
//  consumed by the STARTUP_SPARTAN3E wrapper.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000     stable-input cycles before btn_db changes (10 ms @ 50 MHz)
//  LONG_CYCLES      100000000  debounced-high cycles that make a press long (2 s)
//  ARM_CYCLES       250000000  arm window length after long press release (5 s)
//  MBT_CYCLES       64         width of mbt pulse, cycles
//  LEVEL_MAX        6          top of level range; level wraps LEVEL_MAX->0
// PORTS
//  clkin        in   1  system clock, all logic on posedge
//  rstn         in   1  synchronous reset, active-low
//  btn          in   1  raw button, active-high, asynchronous, bouncing
//  btn_db       out  1  debounced button level
//  short_pulse  out  1  1-cycle strobe on release of a short press
//  long_pulse   out  1  1-cycle strobe when held time reaches LONG_CYCLES
//  level        out  3  current level 0..LEVEL_MAX
//  armed        out  1  high while in ARMED/ARM_PRESS
//  mbt          out  1  multi-boot trigger, active-high, MBT_CYCLES wide
// BEHAVIOUR
//  Reset (rstn=0 at posedge): all outputs 0, level=0, state IDLE, all counters 0,
//   sync flops 0; reset mid-pulse aborts mbt the same cycle.
//  Sync: 2-flop synchronizer on btn; btn_s = second flop.
//  Debounce: cnt clears whenever btn_s==btn_db. Otherwise it increments.
//   When cnt==DEBOUNCE_CYCLES-1 and btn_s!=btn_db, btn_db<=btn_s and cnt<=0.
//   A glitch shorter than DEBOUNCE_CYCLES never changes btn_db.
//   Latency raw->btn_db = 2 + DEBOUNCE_CYCLES cycles.
//  rise/fall = btn_db edge detect (registered previous value).
//  FSM (states IDLE, PRESSED, HELD, ARMED, ARM_PRESS, FIRE):
//   IDLE: rise -> PRESSED, hold counter hc<=0.
//   PRESSED: hc++. If fall, short_pulse=1 and level steps (wrap), go IDLE.
//    If hc==LONG_CYCLES-1 and no fall, long_pulse=1 and go HELD.
//    A fall in that same cycle counts as short.
//   HELD: wait for fall -> ARMED, window counter wc<=0. No level change.
//   ARMED: wc++. rise -> ARM_PRESS. wc==ARM_CYCLES-1 without rise -> IDLE.
//    A rise on the last cycle wins over the timeout.
//   ARM_PRESS: hc++. If fall with hc<LONG_CYCLES, short_pulse=1 and go FIRE;
//    level is not stepped. If hc reaches LONG_CYCLES-1, long_pulse=1, go HELD
//    and re-arm with a fresh window on the next release.
//   FIRE: mbt=1 for exactly MBT_CYCLES cycles, then IDLE. Button input is ignored.
//  All strobes are registered, 1 cycle, and never overlap.
//  armed = (state==ARMED || state==ARM_PRESS).
//  Counters: width $clog2(max param)+1, saturate/clear per state, never wrap.
// TESTING  (bench params: DEBOUNCE=4, LONG=20, ARM=40, MBT=5)
//  1 rstn=0 for 3 cycles with btn=1 -> all outputs 0.
//    After release, btn_db rises exactly 6 cycles after btn sampled high.
//  2 btn glitches high 3 cycles, 4 times, 1-cycle gaps -> btn_db stays 0, no strobes.
//  3 Seven short presses (hold 10 cycles each) -> level 1,2,3,4,5,6,0 and 7 short_pulses.
//    No long_pulse.
//  4 Hold 25 cycles -> long_pulse at held count 20, level unchanged.
//    On release armed=1. Then a 10-cycle press -> short_pulse, mbt high 5 cycles, armed=0.
//  5 Long press then no press for 40 cycles -> armed drops, IDLE, mbt never asserted.
//  6 rstn=0 during cycle 2 of mbt -> mbt=0, level=0 next cycle, FSM in IDLE.

Source files
------------

// File: rtl/button_mbt_ctrl.sv
// Pushbutton front end: synchronizes and debounces one raw button, classifies
// presses as short or long, steps the LED level and fires the multi-boot pulse.
module button_mbt_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned LONG_CYCLES     = 100000000,
  parameter int unsigned ARM_CYCLES      = 250000000,
  parameter int unsigned MBT_CYCLES      = 64,
  parameter int unsigned LEVEL_MAX       = 6
) (
  input  logic       clkin,
  input  logic       rstn,
  input  logic       btn,
  output logic       btn_db,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic [2:0] level,
  output logic       armed,
  output logic       mbt
);

  localparam int unsigned MAX_DL = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int unsigned MAX_AM = (ARM_CYCLES > MBT_CYCLES) ? ARM_CYCLES : MBT_CYCLES;
  localparam int unsigned MAX_P  = (MAX_DL > MAX_AM) ? MAX_DL : MAX_AM;
  localparam int          CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] ZERO      = {CW{1'b0}};
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] ARM_LAST  = CW'(ARM_CYCLES - 1);
  localparam logic [CW-1:0] MBT_LAST  = CW'(MBT_CYCLES - 1);
  localparam logic [2:0]    LVL_TOP   = 3'(LEVEL_MAX);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESSED   = 3'd1,
    HELD      = 3'd2,
    ARMED     = 3'd3,
    ARM_PRESS = 3'd4,
    FIRE      = 3'd5
  } state_e;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == {CW{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CW-1){1'b0}}, 1'b1};
    end
  endfunction

  logic [1:0]    sync_q;
  logic          btn_s;
  logic          btn_db_q, btn_db_d, db_prev_q;
  logic [CW-1:0] db_cnt_q, db_cnt_d;
  logic          rise_s, fall_s;
  state_e        state_q, state_d;
  logic [CW-1:0] hc_q, hc_d, wc_q, wc_d, mc_q, mc_d;
  logic [2:0]    level_q, level_d;
  logic          short_q, short_d, long_q, long_d;
  logic          mbt_q, mbt_d, armed_q, armed_d;

  assign btn_s  = sync_q[1];
  assign rise_s = btn_db_q & ~db_prev_q;
  assign fall_s = ~btn_db_q & db_prev_q;

  // Debounce: btn_db follows btn_s only after DEBOUNCE_CYCLES of steady disagreement
  always_comb begin
    db_cnt_d = db_cnt_q;
    btn_db_d = btn_db_q;
    if (btn_s == btn_db_q) begin
      db_cnt_d = ZERO;
    end else if (db_cnt_q == DB_LAST) begin
      btn_db_d = btn_s;
      db_cnt_d = ZERO;
    end else begin
      db_cnt_d = sat_inc(db_cnt_q);
    end
  end

  // Press classifier FSM: next state, counters, level and strobes
  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    wc_d    = wc_q;
    mc_d    = mc_q;
    level_d = level_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    mbt_d   = 1'b0;
    case (state_q)
      IDLE: begin
        hc_d = ZERO;
        wc_d = ZERO;
        mc_d = ZERO;
        if (rise_s) begin
          state_d = PRESSED;
        end else begin
          state_d = IDLE;
        end
      end
      PRESSED: begin
        hc_d = sat_inc(hc_q);
        // A release on the very last counted cycle is still a short press
        if (fall_s) begin
          short_d = 1'b1;
          level_d = (level_q >= LVL_TOP) ? 3'd0 : level_q + 3'd1;
          state_d = IDLE;
        end else if (hc_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = HELD;
        end else begin
          state_d = PRESSED;
        end
      end
      HELD: begin
        if (fall_s) begin
          wc_d    = ZERO;
          state_d = ARMED;
        end else begin
          state_d = HELD;
        end
      end
      ARMED: begin
        wc_d = sat_inc(wc_q);
        if (rise_s) begin
          hc_d    = ZERO;
          state_d = ARM_PRESS;
        end else if (wc_q == ARM_LAST) begin
          state_d = IDLE;
        end else begin
          state_d = ARMED;
        end
      end
      ARM_PRESS: begin
        hc_d = sat_inc(hc_q);
        if (fall_s) begin
          short_d = 1'b1;
          mc_d    = ZERO;
          state_d = FIRE;
        end else if (hc_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = HELD;
        end else begin
          state_d = ARM_PRESS;
        end
      end
      FIRE: begin
        mbt_d = 1'b1;
        if (mc_q == MBT_LAST) begin
          mc_d    = ZERO;
          state_d = IDLE;
        end else begin
          mc_d    = sat_inc(mc_q);
          state_d = FIRE;
        end
      end
      default: begin
        state_d = IDLE;
        hc_d    = ZERO;
        wc_d    = ZERO;
        mc_d    = ZERO;
      end
    endcase
    armed_d = (state_d == ARMED) || (state_d == ARM_PRESS);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clkin) begin
    if (!rstn) begin
      sync_q    <= 2'b00;
      btn_db_q  <= 1'b0;
      db_prev_q <= 1'b0;
      db_cnt_q  <= ZERO;
      state_q   <= IDLE;
      hc_q      <= ZERO;
      wc_q      <= ZERO;
      mc_q      <= ZERO;
      level_q   <= 3'd0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      mbt_q     <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn};
      btn_db_q  <= btn_db_d;
      db_prev_q <= btn_db_q;
      db_cnt_q  <= db_cnt_d;
      state_q   <= state_d;
      hc_q      <= hc_d;
      wc_q      <= wc_d;
      mc_q      <= mc_d;
      level_q   <= level_d;
      short_q   <= short_d;
      long_q    <= long_d;
      mbt_q     <= mbt_d;
      armed_q   <= armed_d;
    end
  end

  assign btn_db      = btn_db_q;
  assign short_pulse = short_q;
  assign long_pulse  = long_q;
  assign level       = level_q;
  assign armed       = armed_q;
  assign mbt         = mbt_q;

endmodule

// File: tb/tb_button_mbt_ctrl.sv
// Scoreboard bench for button_mbt_ctrl: stimulus queues expected strobes,
// a negedge monitor pops and compares them as the DUT emits them.
module tb_button_mbt_ctrl;

  localparam int K_SHORT = 0;
  localparam int K_LONG  = 1;
  localparam int K_MBT   = 2;
  // db high at edge D, long strobe registered at D+21 -> 22 negedges of btn_db high
  localparam int LONG_AGE = 22;

  typedef struct {
    int kind;
    int lvl;
    int aux;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       btn = 1'b1;
  logic       btn_db, short_pulse, long_pulse, armed, mbt;
  logic [2:0] level;

  exp_t sb_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   db_age = 0;
  int   mbt_run = 0;
  bit   overlap_seen = 1'b0;

  button_mbt_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(20),
    .ARM_CYCLES(40),
    .MBT_CYCLES(5),
    .LEVEL_MAX(6)
  ) dut (
    .clkin(clk),
    .rstn(rstn),
    .btn(btn),
    .btn_db(btn_db),
    .short_pulse(short_pulse),
    .long_pulse(long_pulse),
    .level(level),
    .armed(armed),
    .mbt(mbt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input int lvl, input int aux);
    exp_t e;
    e.kind = kind;
    e.lvl  = lvl;
    e.aux  = aux;
    sb_q.push_back(e);
  endtask

  task automatic take(input int kind, input int lvl, input int aux);
    tests++;
    if (sb_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got kind %0d lvl %0d aux %0d, expected none", kind, lvl, aux);
    end else begin
      mon_e = sb_q.pop_front();
      if (mon_e.kind != kind || mon_e.lvl != lvl || mon_e.aux != aux) begin
        fails++;
        $display("FAIL event: got kind %0d lvl %0d aux %0d, expected kind %0d lvl %0d aux %0d",
                 kind, lvl, aux, mon_e.kind, mon_e.lvl, mon_e.aux);
      end
    end
  endtask

  // Monitor: age of debounced press, strobe overlap, and event pops
  always @(negedge clk) begin
    if (btn_db === 1'b1) db_age = db_age + 1;
    else db_age = 0;
    if ((int'(short_pulse === 1'b1) + int'(long_pulse === 1'b1) + int'(mbt === 1'b1)) > 1)
      overlap_seen = 1'b1;
    if (short_pulse === 1'b1) take(K_SHORT, int'(level), 0);
    if (long_pulse === 1'b1) take(K_LONG, int'(level), db_age);
    if (mbt === 1'b1) begin
      mbt_run = mbt_run + 1;
    end else if (mbt_run != 0) begin
      take(K_MBT, 0, mbt_run);
      mbt_run = 0;
    end
  end

  task automatic press(input int hold, input int gap);
    btn = 1'b1;
    repeat (hold) @(negedge clk);
    btn = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    bit db_seen;
    bit found;

    // 1: reset with button held, then debounce latency
    repeat (3) @(negedge clk);
    chk("reset_outputs", {24'd0, btn_db, short_pulse, long_pulse, level, armed, mbt}, 32'd0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    chk("db_before_latency", {31'd0, btn_db}, 32'd0);
    @(negedge clk);
    chk("db_at_latency", {31'd0, btn_db}, 32'd1);
    btn  = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_again", {24'd0, btn_db, short_pulse, long_pulse, level, armed, mbt}, 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // 2: short glitches never reach btn_db
    db_seen = 1'b0;
    for (int g = 0; g < 4; g++) begin
      btn = 1'b1;
      repeat (3) begin
        @(negedge clk);
        db_seen |= (btn_db === 1'b1);
      end
      btn = 1'b0;
      @(negedge clk);
      db_seen |= (btn_db === 1'b1);
    end
    repeat (10) begin
      @(negedge clk);
      db_seen |= (btn_db === 1'b1);
    end
    chk("glitch_db", {31'd0, db_seen}, 32'd0);

    // 3: seven short presses walk the level and wrap
    for (int p = 0; p < 7; p++) begin
      expect_ev(K_SHORT, (p + 1) % 7, 0);
      press(10, 12);
    end
    chk("level_wrapped", {29'd0, level}, 32'd0);

    // 4: long press arms, short press fires mbt
    expect_ev(K_LONG, 0, LONG_AGE);
    press(25, 10);
    chk("armed_after_long", {31'd0, armed}, 32'd1);
    expect_ev(K_SHORT, 0, 0);
    expect_ev(K_MBT, 0, 5);
    press(10, 20);
    chk("armed_after_fire", {31'd0, armed}, 32'd0);

    // 5: arm window expires
    expect_ev(K_LONG, 0, LONG_AGE);
    press(25, 10);
    chk("armed_window_open", {31'd0, armed}, 32'd1);
    repeat (50) @(negedge clk);
    chk("armed_timeout", {31'd0, armed}, 32'd0);
    chk("level_after_timeout", {29'd0, level}, 32'd0);

    // 6: reset during mbt aborts it
    expect_ev(K_SHORT, 1, 0);
    press(10, 12);
    expect_ev(K_LONG, 1, LONG_AGE);
    press(25, 10);
    expect_ev(K_SHORT, 1, 0);
    press(10, 0);
    found = 1'b0;
    for (int w = 0; w < 40 && !found; w++) begin
      @(negedge clk);
      if (mbt === 1'b1) found = 1'b1;
    end
    chk("mbt_started", {31'd0, found}, 32'd1);
    if (found) begin
      expect_ev(K_MBT, 0, 2);
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      chk("reset_mid_mbt", {28'd0, mbt, level}, 32'd0);
      chk("reset_mid_armed", {31'd0, armed}, 32'd0);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      expect_ev(K_SHORT, 1, 0);
      press(10, 12);
    end

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    chk("strobe_overlap", {31'd0, overlap_seen}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
